// File: rtl/multiplicador_param.sv
// -----------------------------------------------------------------------------
// multiplicador_param
//   Sequential shift-add multiplier with a parameterised operand width.
//   It retires one product bit per cycle and supports signed or unsigned
//   operands, selected per operation. The product is registered and holds
//   its value between operations. A Start/Idle/Done handshake lets the
//   datapath control FSM drive the unit.
//
//   Each operation runs IDLE -> CALC (WIDTH cycles) -> FIX (1) -> DONE (1) -> IDLE.
//   For signed operations the core multiplies the operand magnitudes, and FIX
//   applies the sign. Any width therefore reuses one unsigned datapath.
//
// Parameters
//   WIDTH          operand width in bits (>= 2); the product is 2*WIDTH bits
//
// Ports
//   Clk            clock; all state changes on the rising edge
//   Rst            synchronous active-high reset; overrides St
//   St             start request, sampled only while idle
//   Sgn            1 = two's complement operands, 0 = unsigned (sampled with St)
//   Multiplicador  multiplier operand (sampled with St)
//   Multiplicando  multiplicand operand (sampled with St)
//   Produto        registered product; changes only on FIX->DONE or reset
//   Idle           high while ready to accept St
//   Done           one-cycle pulse; Produto was updated on the edge that raised it
// -----------------------------------------------------------------------------
module multiplicador_param #(
    parameter int WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 St,
    input  logic                 Sgn,
    input  logic [WIDTH-1:0]     Multiplicador,
    input  logic [WIDTH-1:0]     Multiplicando,
    output logic [2*WIDTH-1:0]   Produto,
    output logic                 Idle,
    output logic                 Done
);

    // Iteration counter width, derived from WIDTH.
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_1  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LD = CNT_W'(WIDTH);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;     // {partial product high half, remaining multiplier bits}
    logic [WIDTH-1:0]   mag_b;   // multiplicand magnitude, held for the whole operation
    logic               neg;     // result sign for signed operations

    // Operand magnitudes at load time. -2^(WIDTH-1) negates to itself, and
    // reading that as unsigned gives the correct magnitude 2^(WIDTH-1). No
    // extra bit is needed.
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;

    always_comb begin
        a_neg    = Sgn & Multiplicador[WIDTH-1];
        b_neg    = Sgn & Multiplicando[WIDTH-1];
        mag_a_in = a_neg ? (~Multiplicador + ONE_W) : Multiplicador;
        mag_b_in = b_neg ? (~Multiplicando + ONE_W) : Multiplicando;
    end

    // One shift-add step. The sum is WIDTH+1 bits wide so the carry out of
    // the high half is kept. The carry moves into the top bit during the
    // right shift, which keeps the magnitude product exact in 2*WIDTH bits.
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
        acc_step = {sum, acc[WIDTH-1:1]};
    end

    // Sign fix-up. Negating a zero magnitude gives zero, so a signed zero
    // product stays +0.
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        prod_fix = neg ? (~acc + ONE_2W) : acc;
    end

    // Next-state logic. CALC exits after the step where the counter goes
    // from 1 to 0, which gives exactly WIDTH steps.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (St) state_nxt = S_CALC;
            S_CALC:  if (cnt == CNT_1) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mag_b   <= '0;
            neg     <= 1'b0;
            Produto <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (St) begin
                        acc   <= {{WIDTH{1'b0}}, mag_a_in};
                        mag_b <= mag_b_in;
                        neg   <= a_neg ^ b_neg;
                        cnt   <= CNT_LD;
                    end
                end
                S_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - CNT_1;
                end
                S_FIX: begin
                    Produto <= prod_fix;
                end
                default: ;
            endcase
        end
    end

    // Decode the handshake outputs from the registered state so they do not
    // glitch.
    always_comb begin
        Idle = (state == S_IDLE);
        Done = (state == S_DONE);
    end

endmodule
